ss_stream_accum_decoder: RTL
============================

// Module: ss_stream_accum_decoder
// PURPOSE
//  Stochastic-symbol-to-binary decoder: consumes a 3-bit stochastic symbol stream (e.g. a divider's z_ss)
//  and sums the symbols over a fixed window of WIN_LEN valid symbols. Emits the windowed sum as a binary
//  result with a valid/ready handshake. It is the receiving end for the ss_generator_10_8bit encoders.
//  It replaces the free-running output counter with framed, repeatable measurements.
// PARAMETERS
//  SYM_W    3    symbol width; unsigned value 0..7
//  WIN_LEN  256  valid symbols accumulated per window; must be >=2
//  ACC_W    11   accumulator/result width; must be >= clog2(WIN_LEN*(2**SYM_W-1)+1)
//  CNT_W    localparam = $clog2(WIN_LEN)
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous reset, active-high
//  start         in   1      pulse: begin a new window (taken in IDLE, or in HOLD when ready is also high)
//  abort         in   1      discard the current window and return to IDLE
//  ss_in         in   SYM_W  stochastic symbol
//  ss_valid      in   1      ss_in is valid this cycle
//  busy          out  1      high in ACCUM
//  result        out  ACC_W  windowed symbol sum; held stable while result_valid=1
//  result_valid  out  1      result available
//  result_ready  in   1      consumer accepts result
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; acc=0, cnt=0, result=0, result_valid=0, busy=0.
//  - FSM IDLE->ACCUM on start: acc<=0, cnt<=0. ss_valid in the start cycle is ignored.
//  - ACCUM: each cycle with ss_valid=1, acc<=acc+ss_in (zero-extended), cnt<=cnt+1. ss_valid=0 stalls.
//    The cycle that takes the symbol with cnt==WIN_LEN-1 loads result<=acc+ss_in and goes to HOLD.
//    result_valid rises on the next edge.
//  - Latency: result_valid asserts 1 cycle after the WIN_LEN-th valid symbol is taken.
//  - HOLD: result_valid=1 until result_ready=1 is sampled; then result_valid<=0 and the FSM goes to IDLE.
//    If start=1 in the same cycle, the FSM goes directly to ACCUM with acc and cnt cleared.
//    result keeps its last value after the handshake.
//  - start in ACCUM or HOLD (without ready) is ignored. ss_valid outside ACCUM is ignored.
//  - abort has priority over every other input. In ACCUM or HOLD: acc=0, cnt=0, result_valid=0, state=IDLE.
//    result keeps its previous value.
//  - cnt never wraps. acc cannot overflow when ACC_W is sized as required.
//    No saturation logic; an undersized ACC_W truncates modulo 2**ACC_W.
//  - Reset mid-window: all state cleared at once; the partial sum is lost.
// CONFIGURATION
//  SS_DEC_BIPOLAR_EN defined:
//    - ss_in is signed two's complement (-4..3); acc and result are signed, ss_in is sign-extended.
//    - The range for defaults is -1024..768, which fits 11 bits.
//  SS_DEC_BIPOLAR_EN undefined:
//    - unsigned zero-extend as above.
// TESTING
//  1 rst high mid-window, ss_in=7 -> result=0, result_valid=0, busy=0 immediately; after release, state stays IDLE.
//  2 start, then 256 cycles ss_valid=1, ss_in=7, ready=0
//      -> result=1792 (0x700), result_valid=1 one cycle after the last symbol; held until ready.
//  3 ss_in=3 with ss_valid toggling 1/0 for 512 cycles -> result=768 after the 256th valid symbol; busy=1 throughout.
//  4 HOLD with start=1, ready=1 in the same cycle
//      -> result_valid=0 next cycle, busy=1, new window result=256 for ss_in=1.
//  5 abort after 100 symbols, then start plus 256 symbols of ss_in=2 -> result=512 (no carry-over).
//  6 SS_DEC_BIPOLAR_EN: 256 x ss_in=3'b100 -> result=-1024 (11'h400); 128 x 3 + 128 x 3'b111 -> result=256.

Source files
------------

// File: rtl/ss_stream_accum_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ss_stream_accum_decoder
// Description : Stochastic-symbol-to-binary decoder. Sums SYM_W-bit symbols
//               over a window of WIN_LEN valid symbols. The windowed sum is
//               then offered on a valid/ready result port. Framed
//               measurements replace a free-running output counter.
//
//               Optional feature macro: SS_DEC_BIPOLAR_EN
//                 defined   : symbols are signed two's complement and are
//                             sign-extended. The sum is signed.
//                 undefined : symbols are unsigned and are zero-extended.
//
// Ports       : clk           in   rising-edge clock
//               rst           in   asynchronous reset, active-high
//               start         in   begin a new window (IDLE, or HOLD+ready)
//               abort         in   discard current window, return to IDLE
//               ss_in         in   [SYM_W-1:0] stochastic symbol
//               ss_valid      in   ss_in valid this cycle
//               busy          out  high while accumulating
//               result        out  [ACC_W-1:0] windowed sum, stable while valid
//               result_valid  out  result available
//               result_ready  in   consumer accepts result
//
// Revision    : 1.0 - initial release
// ============================================================================
module ss_stream_accum_decoder #(
    parameter int SYM_W   = 3,
    parameter int WIN_LEN = 256,
    parameter int ACC_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [SYM_W-1:0] ss_in,
    input  logic             ss_valid,
    output logic             busy,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int CNT_W = $clog2(WIN_LEN);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [ACC_W-1:0] result_q;
    logic [ACC_W-1:0] result_d;

    // ------------------------------------------------------------------------
    // Symbol extension to accumulator width
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0] w_sym_ext;
    logic [ACC_W-1:0] w_acc_sum;
    logic             w_take;
    logic             w_last;

`ifdef SS_DEC_BIPOLAR_EN
    // Two's complement symbols. Sign-extension lets the ordinary adder
    // produce a correctly signed running sum.
    assign w_sym_ext = {{(ACC_W-SYM_W){ss_in[SYM_W-1]}}, ss_in};
`else
    assign w_sym_ext = {{(ACC_W-SYM_W){1'b0}}, ss_in};
`endif

    assign w_acc_sum = acc_q + w_sym_ext;
    assign w_take    = (state_q == S_ACCUM) && ss_valid;
    assign w_last    = w_take && (cnt_q == C_CNT_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. abort outranks start, ready and symbols.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!abort && start) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (w_last) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (result_ready) begin
                    // A start that arrives together with the handshake
                    // opens the next window back-to-back.
                    state_d = start ? S_ACCUM : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded from state. result_valid is exactly "in HOLD".
    // Entry into HOLD happens at the edge that takes the last symbol.
    // ------------------------------------------------------------------------
    always_comb begin
        busy         = (state_q == S_ACCUM);
        result_valid = (state_q == S_HOLD);
        result       = result_q;
    end

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (abort) begin
            // Discard the partial window. result keeps its last value.
            acc_d = '0;
            cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end
                end
                S_ACCUM: begin
                    if (w_last) begin
                        // Clear acc and cnt when the window closes. This
                        // keeps cnt from wrapping, and the next window
                        // then starts from zero.
                        result_d = w_acc_sum;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else if (w_take) begin
                        acc_d = w_acc_sum;
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (result_ready && start) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end
                end
                default: begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire
